// File: rtl/i2c_arb_pkg.sv
// Shared widths and FSM state encoding for the I2C arbiter.
package i2c_arb_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;
   localparam int TIMEOUT_W  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BUSY  = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

endpackage

// File: rtl/i2c_arbiter_rr.sv
// Combinational round-robin picker: searches from last_grant+1 upward,
// wrapping at NUM_REQ-1, and returns the first active request.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               valid
);

   localparam int unsigned N = NUM_REQ;

   always_comb begin
      int unsigned idx;
      logic [IDX_W-1:0] sel;
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = (32'(last_grant) + i) % N;
         sel = IDX_W'(idx);
         if (!valid && req[sel]) begin
            valid       = 1'b1;
            grant[sel]  = 1'b1;
            grant_idx   = sel;
         end
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C core among NUM_REQ requesters: round-robin grant, start
// handshake on i2c_ready_i, per-wait-state timeout and done/err pulses.
module i2c_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int          NUM_REQ     = 4,
   parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_i,
   input  logic [7*NUM_REQ-1:0]    addr_i,
   input  logic [8*NUM_REQ-1:0]    data_i,
   output logic [NUM_REQ-1:0]      gnt_o,
   output logic [NUM_REQ-1:0]      done_o,
   output logic [NUM_REQ-1:0]      err_o,
   output logic                    busy_o,
   input  logic                    i2c_ready_i,
   output logic [I2C_ADDR_W-1:0]   i2c_address_o,
   output logic [I2C_DATA_W-1:0]   i2c_data_o,
   output logic                    i2c_start_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                 state, state_nxt;
   logic [NUM_REQ-1:0]     gnt, gnt_nxt;
   logic [IDX_W-1:0]       last_grant, last_grant_nxt;
   logic [I2C_ADDR_W-1:0]  addr, addr_nxt;
   logic [I2C_DATA_W-1:0]  data, data_nxt;
   logic                   start, start_nxt;
   logic [TIMEOUT_W-1:0]   cnt, cnt_nxt;

   logic [NUM_REQ-1:0]     pick_onehot;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req        (req_i),
      .last_grant (last_grant),
      .grant      (pick_onehot),
      .grant_idx  (pick_idx),
      .valid      (pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
         addr       <= '0;
         data       <= '0;
         start      <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         last_grant <= last_grant_nxt;
         addr       <= addr_nxt;
         data       <= data_nxt;
         start      <= start_nxt;
         cnt        <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      gnt_nxt        = gnt;
      last_grant_nxt = last_grant;
      addr_nxt       = addr;
      data_nxt       = data;
      start_nxt      = start;
      cnt_nxt        = cnt;
      case (state)
         IDLE: begin
            if (pick_valid && i2c_ready_i) begin
               state_nxt      = START;
               gnt_nxt        = pick_onehot;
               last_grant_nxt = pick_idx;
               addr_nxt       = addr_i[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
               data_nxt       = data_i[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
               start_nxt      = 1'b1;
               cnt_nxt        = '0;
            end
         end
         START: begin
            if (!i2c_ready_i) begin
               state_nxt = BUSY;
               start_nxt = 1'b0;
               cnt_nxt   = '0;
            end else if (cnt == TIMEOUT_CYC) begin
               state_nxt = ERR;
               start_nxt = 1'b0;
               gnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         BUSY: begin
            if (i2c_ready_i) begin
               state_nxt = DONE;
            end else if (cnt == TIMEOUT_CYC) begin
               state_nxt = ERR;
               gnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
         ERR: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            start_nxt = 1'b0;
         end
      endcase
   end

   // last_grant always holds the current winner, so ERR can still name it
   // after gnt has been cleared.
   assign gnt_o         = gnt;
   assign done_o        = (state == DONE) ? gnt : '0;
   assign err_o         = (state == ERR) ? (NUM_REQ'(1) << last_grant) : '0;
   assign busy_o        = (state != IDLE);
   assign i2c_address_o = addr;
   assign i2c_data_o    = data;
   assign i2c_start_o   = start;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter: single transfer, fairness,
// wrap-around, core-not-ready, reset in BUSY and timeout.
module tb_i2c_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [27:0] addr;
   logic [31:0] data;
   logic        ready;
   logic [3:0]  gnt, done, err;
   logic        busy, start;
   logic [6:0]  i2c_addr;
   logic [7:0]  i2c_data;

   logic [3:0]  req_t;
   logic        ready_t;
   logic [3:0]  gnt_t, done_t, err_t;
   logic        busy_t, start_t;
   logic [6:0]  i2c_addr_t;
   logic [7:0]  i2c_data_t;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   i2c_arbiter #(.NUM_REQ(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .data_i(data),
      .gnt_o(gnt), .done_o(done), .err_o(err), .busy_o(busy),
      .i2c_ready_i(ready), .i2c_address_o(i2c_addr), .i2c_data_o(i2c_data),
      .i2c_start_o(start)
   );

   i2c_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16'd16)) dut_t (
      .clk(clk), .rst_n(rst_n), .req_i(req_t), .addr_i(addr), .data_i(data),
      .gnt_o(gnt_t), .done_o(done_t), .err_o(err_t), .busy_o(busy_t),
      .i2c_ready_i(ready_t), .i2c_address_o(i2c_addr_t), .i2c_data_o(i2c_data_t),
      .i2c_start_o(start_t)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output int waited);
      waited = 0;
      while (gnt == 4'b0 && waited < 50) begin
         tick();
         waited++;
      end
   endtask

   // Core model: ready drops after the third start cycle, rises hold cycles later.
   task automatic serve(input int hold, input int drop_req,
                        output int starts, output int dones, output logic [3:0] dval);
      logic [3:0] gval;
      starts = 0;
      dones  = 0;
      dval   = '0;
      gval   = gnt;
      for (int c = 0; c < 80; c++) begin
         if (start) starts++;
         if (done != 4'b0) begin
            dones++;
            dval = done;
         end
         if (dones != 0) break;
         if (c == 2) ready = 1'b0;
         if (c == 2 + hold) ready = 1'b1;
         if (c == drop_req) req = req & ~gval;
         tick();
      end
   endtask

   task automatic finish_txn(input string tag);
      tick();
      check({tag, "_gnt_clr"}, 32'(gnt), 32'h0);
      check({tag, "_done_clr"}, 32'(done), 32'h0);
      check({tag, "_idle"}, 32'(busy), 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int w, s, d, k, errs_seen, dones_seen;
      logic [3:0] dv;
      logic [3:0] exp_g [5];
      logic [6:0] exp_a [4];
      logic [7:0] exp_d [4];
      logic       any_gnt, any_pulse;

      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      exp_a[0] = 7'h11; exp_a[1] = 7'h48; exp_a[2] = 7'h22; exp_a[3] = 7'h33;
      exp_d[0] = 8'hB0; exp_d[1] = 8'hA5; exp_d[2] = 8'hC2; exp_d[3] = 8'hD3;

      rst_n   = 1'b0;
      req     = '0;
      req_t   = '0;
      ready   = 1'b1;
      ready_t = 1'b1;
      addr    = {7'h33, 7'h22, 7'h48, 7'h11};
      data    = {8'hD3, 8'hC2, 8'hA5, 8'hB0};
      tick();
      tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_start", 32'(start), 32'h0);
      check("rst_addr", 32'(i2c_addr), 32'h0);
      check("rst_data", 32'(i2c_data), 32'h0);
      check("rst_pulses", 32'({done, err}), 32'h0);
      rst_n = 1'b1;
      tick();

      // single request, requester drops req mid-transfer
      req = 4'b0010;
      tick();
      check("single_gnt", 32'(gnt), 32'h2);
      check("single_addr", 32'(i2c_addr), 32'h48);
      check("single_data", 32'(i2c_data), 32'hA5);
      check("single_busy", 32'(busy), 32'h1);
      addr = {7'h33, 7'h22, 7'h7F, 7'h11};
      data = {8'hD3, 8'hC2, 8'h00, 8'hB0};
      serve(20, 6, s, d, dv);
      check("single_starts", 32'(s), 32'd3);
      check("single_done", 32'(dv), 32'h2);
      check("single_addr_hold", 32'(i2c_addr), 32'h48);
      check("single_data_hold", 32'(i2c_data), 32'hA5);
      finish_txn("single");
      addr = {7'h33, 7'h22, 7'h48, 7'h11};
      data = {8'hD3, 8'hC2, 8'hA5, 8'hB0};

      // fairness from reset
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(w);
         check($sformatf("fair_gnt%0d", i), 32'(gnt), 32'(exp_g[i]));
         check($sformatf("fair_addr%0d", i), 32'(i2c_addr), 32'(exp_a[i % 4]));
         check($sformatf("fair_data%0d", i), 32'(i2c_data), 32'(exp_d[i % 4]));
         serve(4, -1, s, d, dv);
         check($sformatf("fair_done%0d", i), 32'(dv), 32'(exp_g[i]));
         if (i == 4) req = '0;
         finish_txn($sformatf("fair%0d", i));
      end

      // wrap-around: grant 3 first, then 0 and 3 again
      req = 4'b1000;
      wait_grant(w);
      check("wrap_g3", 32'(gnt), 32'h8);
      serve(2, -1, s, d, dv);
      req = 4'b1001;
      finish_txn("wrap_a");
      wait_grant(w);
      check("wrap_g0", 32'(gnt), 32'h1);
      serve(2, -1, s, d, dv);
      req = 4'b1000;
      finish_txn("wrap_b");
      wait_grant(w);
      check("wrap_g3b", 32'(gnt), 32'h8);
      serve(2, -1, s, d, dv);
      req = '0;
      finish_txn("wrap_c");

      // core not ready
      ready   = 1'b0;
      req     = 4'b0001;
      any_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         any_gnt = any_gnt | (|gnt) | busy;
      end
      check("nrdy_nogrant", 32'(any_gnt), 32'h0);
      ready = 1'b1;
      tick();
      check("nrdy_grant", 32'(gnt), 32'h1);
      serve(3, 4, s, d, dv);
      check("nrdy_done", 32'(dv), 32'h1);
      finish_txn("nrdy");

      // reset while BUSY
      req = 4'b0100;
      wait_grant(w);
      check("rbusy_gnt", 32'(gnt), 32'h4);
      tick(); tick();
      ready = 1'b0;
      tick(); tick(); tick();
      check("rbusy_inbusy", 32'({busy, start}), 32'h2);
      rst_n = 1'b0;
      #1;
      check("rbusy_gnt0", 32'(gnt), 32'h0);
      check("rbusy_out0", 32'({busy, start, i2c_addr, i2c_data}), 32'h0);
      any_pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         any_pulse = any_pulse | (|done) | (|err);
      end
      ready = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         any_pulse = any_pulse | (|done) | (|err);
         if (gnt == 4'b0) tick();
      end
      check("rbusy_nopulse", 32'(any_pulse), 32'h0);
      wait_grant(w);
      check("rbusy_regrant", 32'(gnt), 32'h4);
      serve(3, -1, s, d, dv);
      req = '0;
      check("rbusy_done", 32'(dv), 32'h4);
      finish_txn("rbusy");

      // timeout on the TIMEOUT_CYC=16 instance, ready never drops
      req_t = 4'b0010;
      tick();
      check("to_gnt", 32'(gnt_t), 32'h2);
      k = 0;
      errs_seen  = 0;
      dones_seen = 0;
      while (err_t == 4'b0 && k < 40) begin
         tick();
         k++;
         if (done_t != 4'b0) dones_seen++;
      end
      if (err_t != 4'b0) errs_seen++;
      check("to_latency", 32'(k), 32'd17);
      check("to_err", 32'(err_t), 32'h2);
      check("to_start", 32'(start_t), 32'h0);
      check("to_gnt_clr", 32'(gnt_t), 32'h0);
      req_t = '0;
      tick();
      if (done_t != 4'b0) dones_seen++;
      if (err_t != 4'b0) errs_seen++;
      check("to_nodone", 32'(dones_seen), 32'd0);
      check("to_one_err", 32'(errs_seen), 32'd1);
      check("to_idle", 32'(busy_t), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one I2C core (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16'hFFFF, giving the maximum clk cycles allowed in each wait state.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port req_i, input, NUM_REQ, one transfer request per requester, held high until done/err.
REQ-006 The block SHALL have port addr_i, input, 7*NUM_REQ, the 7-bit slave address per requester, with requester k at bits [7k+6:7k].
REQ-007 The block SHALL have port data_i, input, 8*NUM_REQ, the data byte per requester, with requester k at bits [8k+7:8k].
REQ-008 The block SHALL have port gnt_o, output, NUM_REQ, the one-hot grant, high for the whole transaction.
REQ-009 The block SHALL have port done_o, output, NUM_REQ, a one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port err_o, output, NUM_REQ, a one-cycle timeout pulse to the granted requester.
REQ-011 The block SHALL have port busy_o, output, 1, which is high whenever state != IDLE.
REQ-012 The block SHALL have port i2c_ready_i, input, 1, the ready status from the I2C core (high = idle).
REQ-013 The block SHALL have port i2c_address_o, output, 7, the registered address to the I2C core.
REQ-014 The block SHALL have port i2c_data_o, output, 8, the registered data to the I2C core.
REQ-015 The block SHALL have port i2c_start_o, output, 1, the start level to the I2C core.

Function
REQ-016 The block SHALL have FSM states IDLE, START, BUSY and DONE, plus ERR.
REQ-017 IDLE SHALL move to START in one cycle when any req_i bit is high and i2c_ready_i=1; if i2c_ready_i=0, the FSM SHALL stay in IDLE and not grant.
REQ-018 On the IDLE->START edge, the block SHALL register gnt_o (one-hot winner), i2c_address_o/i2c_data_o (winner's fields) and i2c_start_o=1 in the same clock.
REQ-019 The winner SHALL be chosen round-robin: search starts at last_grant+1, wraps at NUM_REQ-1 to 0, and last_grant updates only on grant; after reset, search starts at requester 0.
REQ-020 In START, i2c_start_o SHALL stay 1 until i2c_ready_i=0 is sampled, then the FSM SHALL go to BUSY with i2c_start_o=0.
REQ-021 In BUSY, when i2c_ready_i=1 is sampled, the FSM SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with done_o[winner]=1, then return to IDLE with gnt_o cleared.
REQ-023 i2c_address_o/i2c_data_o SHALL hold stable from grant until the next grant; addr_i/data_i changes during a transaction SHALL be ignored.
REQ-024 A 16-bit timeout counter SHALL clear on entry to START and to BUSY and increment each cycle in those states; when it equals TIMEOUT_CYC, the FSM SHALL go to ERR.
REQ-025 ERR SHALL last one cycle with err_o[winner]=1, i2c_start_o=0 and gnt_o cleared, then return to IDLE.
REQ-026 Deassertion of req_i by the granted requester mid-transaction SHALL NOT abort the transaction; done_o/err_o SHALL still be issued.
REQ-027 New requests arriving while busy_o=1 SHALL be held pending and SHALL be arbitrated only in IDLE; minimum IDLE dwell is one cycle between transactions.
REQ-028 At most one bit of gnt_o, done_o and err_o SHALL be high at any time.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=IDLE, gnt_o=0, done_o=0, err_o=0, busy_o=0, i2c_start_o=0, i2c_address_o=7'h00, i2c_data_o=8'h00, last_grant=NUM_REQ-1 and timeout counter=0.
REQ-030 Assertion of rst_n mid-transaction SHALL abandon the transaction without issuing done_o or err_o; after release, the FSM SHALL re-arbitrate from IDLE.

Structure
REQ-031 Package i2c_arb_pkg SHALL hold the FSM state encoding, I2C_ADDR_W=7, I2C_DATA_W=8 and TIMEOUT_W=16.
REQ-032 The block SHALL instantiate one sub-module, rr_arbiter (combinational round-robin picker: req vector + last_grant -> one-hot winner + index).

Verification
REQ-033 The bench SHALL cover single request: req_i=4'b0010, addr1=7'h48, data1=8'hA5, core drops ready 3 cycles after start and raises it 20 cycles later -> gnt_o=4'b0010, i2c_address_o=7'h48, i2c_data_o=8'hA5, exactly one done_o[1] pulse, i2c_start_o high exactly 3 cycles.
REQ-034 The bench SHALL cover fairness: req_i=4'b1111 held continuously -> grants in order 0,1,2,3,0, with one done_o per requester.
REQ-035 The bench SHALL cover wrap-around: last_grant=3 with req_i=4'b1001 -> next grant is requester 0, then requester 3.
REQ-036 The bench SHALL cover timeout: TIMEOUT_CYC=16, i2c_ready_i never drops after start -> err_o[winner] pulses 17 cycles after grant, i2c_start_o=0, no done_o.
REQ-037 The bench SHALL cover core not ready: i2c_ready_i=0 with req_i=4'b0001 -> no grant until ready rises, grant on the next cycle.
REQ-038 The bench SHALL cover reset in BUSY: rst_n pulsed low in BUSY -> all outputs return to their reset values immediately, with no done_o or err_o issued.
